// File: rtl/mem_stage.sv
// Memory stage: EX/MEM pipeline register plus a request/done sequencer for a variable-latency data memory.
// Stalls upstream while an access is outstanding. An access ends with an error if it does not complete
// within TIMEOUT cycles.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_IDLE | slot holds a non-memory op, a bubble, or a memory op about to issue
// S_WAIT | request issued; counting cycles until mem_done or timeout
// S_RESP | access finished; instruction retires at the end of this cycle
module mem_stage #(
   parameter int DATA_W  = 16,
   parameter int REG_W   = 3,
   parameter int TIMEOUT = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              validX,
   input  logic [DATA_W-1:0] aluFinalX,
   input  logic [DATA_W-1:0] addPCX,
   input  logic [DATA_W-1:0] imm8X,
   input  logic [DATA_W-1:0] wrtDataX,
   input  logic              memReadX,
   input  logic              memWriteX,
   input  logic              regWriteX,
   input  logic [1:0]        wbDataSelX,
   input  logic [REG_W-1:0]  writeRegX,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_done,
   output logic              stallM,
   output logic              validM,
   output logic              regWriteM,
   output logic [REG_W-1:0]  writeRegM,
   output logic [1:0]        wbDataSelM,
   output logic [DATA_W-1:0] m2xALUData,
   output logic [DATA_W-1:0] m2xAddPCData,
   output logic [DATA_W-1:0] m2xImm8Data,
   output logic [DATA_W-1:0] m2xMemData,
   output logic              errM
);

   localparam int CNT_W = $clog2(TIMEOUT) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t              state_q, state_d;
   logic                valid_q, mem_read_q, mem_write_q, reg_write_q;
   logic [1:0]          wb_sel_q;
   logic [REG_W-1:0]    write_reg_q;
   logic [DATA_W-1:0]   alu_q, add_pc_q, imm8_q, wrt_data_q, mem_data_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                err_q;
   logic                mem_op, unaligned, stall, req;

   assign mem_op    = valid_q & (mem_read_q | mem_write_q);
   assign unaligned = mem_op & alu_q[0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q     <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         reg_write_q <= 1'b0;
         wb_sel_q    <= '0;
         write_reg_q <= '0;
         alu_q       <= '0;
         add_pc_q    <= '0;
         imm8_q      <= '0;
         wrt_data_q  <= '0;
      end else if (!stall) begin
         valid_q     <= validX;
         mem_read_q  <= memReadX;
         mem_write_q <= memWriteX;
         reg_write_q <= regWriteX;
         wb_sel_q    <= wbDataSelX;
         write_reg_q <= writeRegX;
         alu_q       <= aluFinalX;
         add_pc_q    <= addPCX;
         imm8_q      <= imm8X;
         wrt_data_q  <= wrtDataX;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         mem_data_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_WAIT) cnt_q <= cnt_q + 1'b1;
         else                   cnt_q <= '0;
         // a new instruction entering the slot starts with a clean error flag
         if (!stall)
            err_q <= 1'b0;
         else if (state_q == S_WAIT && !mem_done && cnt_q == CNT_LAST)
            err_q <= 1'b1;
         if (state_q == S_WAIT && mem_done && mem_read_q)
            mem_data_q <= mem_rdata;
      end
   end

   always_comb begin
      state_d = state_q;
      stall   = 1'b0;
      req     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (mem_op && !unaligned) begin
               req     = 1'b1;
               stall   = 1'b1;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            stall = 1'b1;
            // done wins over a timeout reached in the same cycle
            if (mem_done || cnt_q == CNT_LAST) state_d = S_RESP;
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign mem_en       = req;
   assign mem_wr       = mem_write_q;
   assign mem_addr     = alu_q;
   assign mem_wdata    = wrt_data_q;
   assign stallM       = stall;
   assign validM       = valid_q;
   assign errM         = err_q | unaligned;
   assign regWriteM    = valid_q & reg_write_q & ~errM;
   assign writeRegM    = write_reg_q;
   assign wbDataSelM   = wb_sel_q;
   assign m2xALUData   = alu_q;
   assign m2xAddPCData = add_pc_q;
   assign m2xImm8Data  = imm8_q;
   assign m2xMemData   = mem_data_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, bubble, load, store, unaligned access,
// timeout, done-at-timeout priority, and reset in the middle of an access.
module tb_mem_stage;

   logic        clk, rst;
   logic        validX, memReadX, memWriteX, regWriteX;
   logic [15:0] aluFinalX, addPCX, imm8X, wrtDataX;
   logic [1:0]  wbDataSelX;
   logic [2:0]  writeRegX;
   logic        mem_en, mem_wr, mem_done;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic        stallM, validM, regWriteM, errM;
   logic [2:0]  writeRegM;
   logic [1:0]  wbDataSelM;
   logic [15:0] m2xALUData, m2xAddPCData, m2xImm8Data, m2xMemData;

   int checks = 0;
   int errors = 0;
   int st_cnt, en_cnt;

   mem_stage #(.DATA_W(16), .REG_W(3), .TIMEOUT(32)) dut (
      .clk(clk), .rst(rst),
      .validX(validX), .aluFinalX(aluFinalX), .addPCX(addPCX), .imm8X(imm8X),
      .wrtDataX(wrtDataX), .memReadX(memReadX), .memWriteX(memWriteX),
      .regWriteX(regWriteX), .wbDataSelX(wbDataSelX), .writeRegX(writeRegX),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_done(mem_done),
      .stallM(stallM), .validM(validM), .regWriteM(regWriteM), .writeRegM(writeRegM),
      .wbDataSelM(wbDataSelM), .m2xALUData(m2xALUData), .m2xAddPCData(m2xAddPCData),
      .m2xImm8Data(m2xImm8Data), .m2xMemData(m2xMemData), .errM(errM)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_x(input logic v, input logic [15:0] alu, input logic [15:0] apc,
                        input logic [15:0] imm, input logic [15:0] wd, input logic rd,
                        input logic wr, input logic rw, input logic [1:0] sel,
                        input logic [2:0] wreg);
      validX = v; aluFinalX = alu; addPCX = apc; imm8X = imm; wrtDataX = wd;
      memReadX = rd; memWriteX = wr; regWriteX = rw; wbDataSelX = sel; writeRegX = wreg;
   endtask

   // Starting at the first cycle of a latched memory op, run until stall drops.
   // mem_done is driven high during cycle done_at (negative = never).
   task automatic run_mem(input int done_at, input logic [15:0] rdata,
                          output int stalls, output int reqs);
      stalls = 0;
      reqs   = 0;
      for (int c = 0; c < 60; c++) begin
         mem_done  = (c == done_at);
         mem_rdata = rdata;
         if (!stallM) break;
         stalls++;
         if (mem_en) reqs++;
         step();
      end
      mem_done = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      mem_done = 1'b0;
      mem_rdata = '0;
      set_x(0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 2'b00, 3'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_stall", stallM, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_valid", validM, 0);
      chk("rst_alu", m2xALUData, 0);
      chk("rst_err", errM, 0);
      rst = 1'b1;

      // ALU op
      set_x(1, 16'h1234, 16'h0002, 16'h0007, 16'h0, 0, 0, 1, 2'b10, 3'd5);
      step();
      chk("add_alu", m2xALUData, 16'h1234);
      chk("add_rw", regWriteM, 1);
      chk("add_wreg", writeRegM, 5);
      chk("add_sel", wbDataSelM, 2'b10);
      chk("add_apc", m2xAddPCData, 16'h0002);
      chk("add_imm", m2xImm8Data, 16'h0007);
      chk("add_stall", stallM, 0);
      chk("add_mem_en", mem_en, 0);

      // bubble carrying load/regwrite bits
      set_x(0, 16'h0040, 16'h0, 16'h0, 16'h0, 1, 0, 1, 2'b01, 3'd1);
      step();
      chk("bub_valid", validM, 0);
      chk("bub_rw", regWriteM, 0);
      chk("bub_mem_en", mem_en, 0);
      chk("bub_stall", stallM, 0);

      // load 0x0040, done three cycles after request
      set_x(1, 16'h0040, 16'h0, 16'h0, 16'h0, 1, 0, 1, 2'b01, 3'd3);
      step();
      chk("ld_mem_en", mem_en, 1);
      chk("ld_mem_wr", mem_wr, 0);
      chk("ld_addr", mem_addr, 16'h0040);
      set_x(1, 16'h5555, 16'h0, 16'h0, 16'h0, 0, 0, 1, 2'b10, 3'd6);
      run_mem(3, 16'hBEEF, st_cnt, en_cnt);
      chk("ld_stall_cycles", st_cnt, 4);
      chk("ld_req_cycles", en_cnt, 1);
      chk("ld_rdata", m2xMemData, 16'hBEEF);
      chk("ld_resp_alu", m2xALUData, 16'h0040);
      chk("ld_resp_rw", regWriteM, 1);
      chk("ld_resp_err", errM, 0);
      step();
      chk("ld_next_alu", m2xALUData, 16'h5555);
      chk("ld_next_wreg", writeRegM, 6);

      // store 0x0010 <- 0xA5A5, done the cycle after request
      set_x(1, 16'h0010, 16'h0, 16'h0, 16'hA5A5, 0, 1, 0, 2'b00, 3'd0);
      step();
      chk("st_mem_en", mem_en, 1);
      chk("st_mem_wr", mem_wr, 1);
      chk("st_wdata", mem_wdata, 16'hA5A5);
      chk("st_addr", mem_addr, 16'h0010);
      set_x(0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 2'b00, 3'd0);
      run_mem(1, 16'h1111, st_cnt, en_cnt);
      chk("st_stall_cycles", st_cnt, 2);
      chk("st_memdata_kept", m2xMemData, 16'hBEEF);
      chk("st_err", errM, 0);
      step();

      // unaligned load
      set_x(1, 16'h0041, 16'h0, 16'h0, 16'h0, 1, 0, 1, 2'b01, 3'd4);
      step();
      chk("ua_mem_en", mem_en, 0);
      chk("ua_stall", stallM, 0);
      chk("ua_err", errM, 1);
      chk("ua_rw", regWriteM, 0);
      set_x(1, 16'h0101, 16'h0, 16'h0, 16'h0, 0, 0, 1, 2'b10, 3'd2);
      step();
      chk("ua_next_err", errM, 0);
      chk("ua_next_rw", regWriteM, 1);

      // load that never completes
      set_x(1, 16'h0080, 16'h0, 16'h0, 16'h0, 1, 0, 1, 2'b01, 3'd1);
      step();
      set_x(1, 16'h0202, 16'h0, 16'h0, 16'h0, 0, 0, 1, 2'b10, 3'd2);
      run_mem(-1, 16'h0, st_cnt, en_cnt);
      chk("to_stall_cycles", st_cnt, 33);
      chk("to_err", errM, 1);
      chk("to_rw", regWriteM, 0);
      chk("to_memdata_kept", m2xMemData, 16'hBEEF);
      step();
      chk("to_next_err", errM, 0);
      chk("to_next_alu", m2xALUData, 16'h0202);

      // done arriving on the timeout cycle wins
      set_x(1, 16'h0090, 16'h0, 16'h0, 16'h0, 1, 0, 1, 2'b01, 3'd1);
      step();
      set_x(0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 2'b00, 3'd0);
      run_mem(32, 16'hC0DE, st_cnt, en_cnt);
      chk("tie_stall_cycles", st_cnt, 33);
      chk("tie_err", errM, 0);
      chk("tie_rdata", m2xMemData, 16'hC0DE);
      chk("tie_rw", regWriteM, 1);
      step();

      // reset in the middle of WAIT
      set_x(1, 16'h0020, 16'h0, 16'h0, 16'h0, 1, 0, 1, 2'b01, 3'd1);
      step();
      set_x(0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 2'b00, 3'd0);
      step();
      step();
      chk("mid_wait_stall", stallM, 1);
      rst = 1'b0;
      #1;
      chk("mid_rst_stall", stallM, 0);
      chk("mid_rst_valid", validM, 0);
      chk("mid_rst_memdata", m2xMemData, 0);
      chk("mid_rst_alu", m2xALUData, 0);
      #1;
      rst = 1'b1;
      mem_done = 1'b1;
      mem_rdata = 16'hDEAD;
      step();
      mem_done = 1'b0;
      chk("stray_memdata", m2xMemData, 0);
      chk("stray_stall", stallM, 0);
      chk("stray_mem_en", mem_en, 0);

      // normal load after reset
      set_x(1, 16'h0030, 16'h0, 16'h0, 16'h0, 1, 0, 1, 2'b01, 3'd7);
      step();
      set_x(0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 2'b00, 3'd0);
      run_mem(2, 16'h4321, st_cnt, en_cnt);
      chk("post_stall_cycles", st_cnt, 3);
      chk("post_rdata", m2xMemData, 16'h4321);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage that sits directly downstream of execute.
- Latches execute results (EX/MEM register) and runs data-memory access on a variable-latency memory through a request/done handshake.
- Stalls the upstream pipeline while an access is outstanding.
- Produces write-back values and the m2x forwarding data consumed by execute.

Parameters:
DATA_W, 16, datapath width
REG_W, 3, destination register index width
TIMEOUT, 32, max cycles waiting for mem_done before flagging error

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous active-low reset (asserted when 0)
validX  input  1  instruction in EX is real (0 = bubble)
aluFinalX  input  DATA_W  ALU/set result from execute
addPCX  input  DATA_W  link/next PC from execute
imm8X  input  DATA_W  extended imm8 (LBI path)
wrtDataX  input  DATA_W  forwarded store data from execute
memReadX  input  1  load
memWriteX  input  1  store
regWriteX  input  1  writes register file
wbDataSelX  input  2  00 addPC, 01 memory, 10 ALU, 11 imm8
writeRegX  input  REG_W  destination register
mem_en  output  1  memory request strobe
mem_wr  output  1  1 = write, 0 = read; valid with mem_en
mem_addr  output  DATA_W  access address
mem_wdata  output  DATA_W  store data
mem_rdata  input  DATA_W  read data; valid when mem_done=1
mem_done  input  1  access complete, one-cycle pulse
stallM  output  1  freeze PC, IF/ID and ID/EX; hold execute inputs stable
validM  output  1  EX/MEM slot holds a real instruction
regWriteM  output  1  register write enable to WB (qualified)
writeRegM  output  REG_W  destination register
wbDataSelM  output  2  held select
m2xALUData  output  DATA_W  latched aluFinal
m2xAddPCData  output  DATA_W  latched addPC
m2xImm8Data  output  DATA_W  latched imm8
m2xMemData  output  DATA_W  captured load data
errM  output  1  unaligned address or timeout on the current instruction

Behaviour:
- Reset (rst=0, async): every EX/MEM register, load-data register, counter and err flag cleared to 0. FSM goes to IDLE. All outputs are 0, including mem_en and stallM.
- EX/MEM register: loads all X inputs on a clk edge when stallM=0. Holds them when stallM=1.
- memOp = validM & (memReadM | memWriteM).
- unaligned = memOp & mem_addr[0].
- mem_addr = m2xALUData.
- mem_wdata = latched wrtData.
- mem_wr = memWriteM.
- FSM states:
  - IDLE: if memOp & !unaligned, assert mem_en for this cycle only, stallM=1, go to WAIT and clear the counter. Otherwise stallM=0 and stay in IDLE.
  - WAIT: mem_en=0, stallM=1, counter increments each cycle.
    - mem_done=1: capture mem_rdata into m2xMemData (loads only; stores leave it unchanged), go to RESP.
    - counter reaches TIMEOUT-1 without mem_done: set errM, go to RESP.
  - RESP: stallM=0; the instruction leaves the stage at the end of this cycle, and the next instruction is latched. Go to IDLE.
- Minimum load/store residency: 3 cycles (IDLE, WAIT, RESP). Non-memory instructions and bubbles spend 1 cycle.
- mem_done outside WAIT is ignored.
- mem_done on the same cycle the timeout is reached: done takes priority and errM is not set.
- Unaligned: no request, no stall, errM=1 for that instruction's single cycle.
- regWriteM = validM & regWriteX_latched & !errM.
- errM clears when a new instruction is latched.
- A bubble (validX=0) latches validM=0, which forces regWriteM=0 and suppresses any memory request.
- Reset during WAIT: FSM returns to IDLE immediately. A late mem_done after reset release is ignored, because the FSM is not in WAIT.
- Forwarding outputs are pure register outputs; no combinational path from X inputs.

Test Plan:
- ADD result 0x1234, regWriteX=1, wbDataSelX=10, writeReg=5 → next cycle m2xALUData=0x1234, regWriteM=1, writeRegM=5, stallM=0, mem_en never asserted.
- Load at addr 0x0040, mem_done 3 cycles after request with rdata 0xBEEF:
  - mem_en=1 for exactly one cycle with mem_wr=0 and mem_addr=0x0040.
  - stallM high for 4 cycles.
  - m2xMemData=0xBEEF in RESP.
  - Next instruction latched after RESP.
- Store to 0x0010 with data 0xA5A5, mem_done the cycle after request → mem_wr=1, mem_wdata=0xA5A5, stallM high for exactly 2 cycles, m2xMemData unchanged.
- Load at addr 0x0041 → no mem_en, stallM=0, errM=1 for one cycle, regWriteM=0.
- Load with mem_done never asserted, TIMEOUT=32 → errM=1 after 32 WAIT cycles, then stall released.
- Assert rst=0 mid-WAIT → outputs 0 immediately. After release, a stray mem_done pulse produces no capture and no state change.
